noise_gate: RTL and testbench

Audio noise gate that consumes the one-bit silence flag produced by the frequency-machine silence detector and applies a smooth gain envelope to the sample stream. It holds the gate open for a programmable hold time, then fades the signal to zero when silence persists, and fades back in quickly when signal returns. It sits in the sample path directly after the detector's data tap and runs at the system clock, advancing only on sample ticks.

---
 rtl/noise_gate_if.sv | 26 ++
 rtl/noise_gate.sv | 119 +++++++++++
 tb/tb_noise_gate.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/noise_gate_if.sv
// noise_gate_if: sample-path bundle between the silence detector tap and the gate.
//   sample_tick_i : one-cycle strobe per audio sample
//   silence_i     : silence flag, meaningful only with sample_tick_i
//   data_i        : signed input sample, valid with sample_tick_i
//   data_o        : gated sample, registered
//   gated_o       : high while the gate is fully closed
// master drives the inputs of the gate; slave is the gate itself.
interface noise_gate_if #(
    parameter int DW = 16
);
    logic          sample_tick_i;
    logic          silence_i;
    logic [DW-1:0] data_i;
    logic [DW-1:0] data_o;
    logic          gated_o;

    modport master (
        output sample_tick_i, silence_i, data_i,
        input  data_o, gated_o
    );

    modport slave (
        input  sample_tick_i, silence_i, data_i,
        output data_o, gated_o
    );
endinterface

// File: rtl/noise_gate.sv
// noise_gate: applies a hold/fade gain envelope to a sample stream, driven by
// a one-bit silence flag. Silence first holds the gate open for HOLD ticks,
// then fades gain by 1 per tick down to zero; signal returning fades gain back
// up by ATTACK_STEP per tick. All state advances only on sample ticks.
//   clk_i   : system clock
//   rst_n_i : asynchronous reset, active low
//   bus     : noise_gate_if slave (tick, silence, data in; data out, gated flag)
module noise_gate #(
    parameter int DW          = 16,
    parameter int RAMP_BW     = 10,
    parameter int HOLD        = 4410,
    parameter int ATTACK_STEP = 8
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    noise_gate_if.slave  bus
);
    localparam int GW = RAMP_BW + 1;          // gain register width
    localparam int PW = DW + RAMP_BW + 1;     // product width
    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

    localparam int              GMAX_I = 1 << RAMP_BW;
    localparam logic [GW-1:0]   GMAX   = GW'(GMAX_I);
    localparam logic [GW-1:0]   STEP   = GW'(ATTACK_STEP);
    localparam logic [GW-1:0]   G_ONE  = GW'(1);
    localparam logic [GW-1:0]   G_RISE_TOP = GW'(GMAX_I - ATTACK_STEP);
    localparam logic [CW-1:0]   HOLD_LAST  = CW'(HOLD - 1);

    typedef enum logic [2:0] {
        S_OPEN,
        S_HOLD,
        S_FADE_OUT,
        S_CLOSED,
        S_FADE_IN
    } state_t;

    state_t        state, next_state;
    logic [GW-1:0] gain, next_gain;
    logic [CW-1:0] cnt, next_cnt;

    // Scaling: gain is non-negative, so zero-extend it; the product magnitude
    // never exceeds 2^(DW-1) * GMAX, which fits PW signed bits.
    logic signed [PW-1:0] d_ext, g_ext, prod;
    logic                 unused_prod_bits;

    assign d_ext = {{(RAMP_BW+1){bus.data_i[DW-1]}}, bus.data_i};
    assign g_ext = {{DW{1'b0}}, gain};
    assign prod  = d_ext * g_ext;
    // Taking bits [RAMP_BW +: DW] is the arithmetic right shift by RAMP_BW
    // (floor rounding) followed by truncation to DW bits.
    assign unused_prod_bits = ^{prod[PW-1], prod[RAMP_BW-1:0]};

    always_comb begin
        next_state = state;
        next_gain  = gain;
        next_cnt   = cnt;
        case (state)
            S_OPEN: begin
                if (bus.silence_i) begin
                    next_state = S_HOLD;
                    next_cnt   = '0;
                end
            end
            S_HOLD: begin
                if (!bus.silence_i)
                    next_state = S_OPEN;
                else if (cnt == HOLD_LAST)
                    next_state = S_FADE_OUT;
                else
                    next_cnt = cnt + CW'(1);
            end
            S_FADE_OUT: begin
                if (!bus.silence_i)
                    next_state = S_FADE_IN;
                else if (gain <= G_ONE) begin
                    // <= also covers entry from FADE_IN at gain 0
                    next_gain  = '0;
                    next_state = S_CLOSED;
                end else
                    next_gain = gain - G_ONE;
            end
            S_CLOSED: begin
                if (!bus.silence_i)
                    next_state = S_FADE_IN;
            end
            S_FADE_IN: begin
                if (bus.silence_i)
                    next_state = S_FADE_OUT;
                else if (gain >= G_RISE_TOP) begin
                    next_gain  = GMAX;
                    next_state = S_OPEN;
                end else
                    next_gain = gain + STEP;
            end
            default: begin
                next_state = S_OPEN;
                next_gain  = GMAX;
                next_cnt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= S_OPEN;
            gain       <= GMAX;
            cnt        <= '0;
            bus.data_o <= '0;
        end else if (bus.sample_tick_i) begin
            // output uses the gain in effect before this tick's update
            bus.data_o <= prod[RAMP_BW +: DW];
            state      <= next_state;
            gain       <= next_gain;
            cnt        <= next_cnt;
        end
    end

    assign bus.gated_o = (state == S_CLOSED);
endmodule

// File: tb/tb_noise_gate.sv
// tb_noise_gate: table of per-tick {reset, silence, data, expected data_o,
// expected gated_o} records plus hand-written sequences for the no-tick hold
// and asynchronous reset cases. Expected values are queued when a tick is
// driven and popped after the following clock edge.
module tb_noise_gate;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    noise_gate_if #(.DW(DW)) bus();

    noise_gate #(.DW(DW), .RAMP_BW(4), .HOLD(4), .ATTACK_STEP(4)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    typedef struct {
        bit          rst;
        bit          sil;
        logic [15:0] din;
        logic [15:0] exp_d;
        bit          exp_g;
    } vec_t;

    typedef struct {
        logic [15:0] d;
        bit          g;
        int          id;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void add(bit r, bit s, logic [15:0] d, logic [15:0] e, bit g);
        vec_t v;
        v.rst = r; v.sil = s; v.din = d; v.exp_d = e; v.exp_g = g;
        vecs.push_back(v);
    endfunction

    // Expected output at tick k (1-based) of a continuous silent run from OPEN
    // with data 0x1000: six full samples, then gain 22-k.
    function automatic logic [15:0] fade_exp(int k);
        if (k <= 6) return 16'h1000;
        if (k >= 22) return 16'h0000;
        return 16'((22 - k) * 256);
    endfunction

    task automatic check(string name, logic [15:0] act, logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic tick(bit s, logic [15:0] d, logic [15:0] e, bit g, int id);
        exp_t x, got;
        @(negedge clk);
        bus.sample_tick_i = 1'b1;
        bus.silence_i     = s;
        bus.data_i        = d;
        x.d = e; x.g = g; x.id = id;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        bus.sample_tick_i = 1'b0;
        got = exp_q.pop_front();
        check($sformatf("data_o vec%0d", got.id), bus.data_o, got.d);
        check($sformatf("gated_o vec%0d", got.id), {15'd0, bus.gated_o}, {15'd0, got.g});
    endtask

    initial begin
        bus.sample_tick_i = 1'b0;
        bus.silence_i     = 1'b0;
        bus.data_i        = '0;

        // passthrough
        add(1, 0, 16'h1234, 16'h1234, 0);
        add(0, 0, 16'h1234, 16'h1234, 0);
        add(0, 0, 16'h1234, 16'h1234, 0);
        // full fade-out, then fade back in from CLOSED
        for (int k = 1; k <= 23; k++)
            add(k == 1, 1, 16'h1000, fade_exp(k), k >= 21);
        add(0, 0, 16'h1000, 16'h0000, 0);
        add(0, 0, 16'h1000, 16'h0000, 0);
        add(0, 0, 16'h1000, 16'h0400, 0);
        add(0, 0, 16'h1000, 16'h0800, 0);
        add(0, 0, 16'h1000, 16'h0C00, 0);
        add(0, 0, 16'h1000, 16'h1000, 0);
        add(0, 0, 16'h1000, 16'h1000, 0);
        // reversal at G=10
        for (int k = 1; k <= 11; k++)
            add(k == 1, 1, 16'h1000, fade_exp(k), 0);
        add(0, 0, 16'h1000, 16'h0A00, 0);
        add(0, 0, 16'h1000, 16'h0A00, 0);
        add(0, 0, 16'h1000, 16'h0E00, 0);
        add(0, 0, 16'h1000, 16'h1000, 0);
        add(0, 0, 16'h1000, 16'h1000, 0);
        // hold glitch: 3 silent ticks, recover, then 6 silent ticks still full
        for (int i = 0; i < 12; i++) begin
            logic [15:0] d;
            d = 16'h2000 + 16'(i * 16'h0111);
            add(i == 0, (i < 3) || (i >= 6), d, d, 0);
        end
        // negative rounding, then FADE_IN -> FADE_OUT reversal at low gain
        for (int k = 1; k <= 21; k++) begin
            if (k == 14)      add(0, 1, 16'h8000, 16'hC000, 0);
            else if (k == 21) add(0, 1, 16'hFFFF, 16'hFFFF, 1);
            else              add(k == 1, 1, 16'h1000, fade_exp(k), 0);
        end
        add(0, 0, 16'h1000, 16'h0000, 0);
        add(0, 0, 16'h1000, 16'h0000, 0);
        add(0, 1, 16'h1000, 16'h0400, 0);
        add(0, 1, 16'h1000, 16'h0400, 0);
        add(0, 1, 16'h1000, 16'h0300, 0);
        add(0, 1, 16'h1000, 16'h0200, 0);
        add(0, 1, 16'h0001, 16'h0000, 1);

        // reset state, checked with no clock edge yet seen
        #1;
        check("reset data_o", bus.data_o, 16'h0000);
        check("reset gated_o", {15'd0, bus.gated_o}, 16'h0000);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) do_reset();
            tick(vecs[i].sil, vecs[i].din, vecs[i].exp_d, vecs[i].exp_g, i);
        end

        // gate is CLOSED here: async reset must drop gated_o at once
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async rst gated_o closed", {15'd0, bus.gated_o}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // no tick: data_o holds while inputs wiggle
        tick(0, 16'h1234, 16'h1234, 0, 1000);
        bus.data_i    = 16'h5555;
        bus.silence_i = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("no-tick hold data_o", bus.data_o, 16'h1234);
            check("no-tick hold gated_o", {15'd0, bus.gated_o}, 16'h0000);
        end

        // async reset mid fade-out, then first tick after release
        for (int k = 1; k <= 10; k++)
            tick(1, 16'h1000, fade_exp(k), 0, 2000 + k);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async rst data_o", bus.data_o, 16'h0000);
        check("async rst gated_o", {15'd0, bus.gated_o}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        tick(0, 16'h7FFF, 16'h7FFF, 0, 3000);
        // reset must also restore OPEN/hold counter: a fresh silent run is full for 6 ticks
        for (int k = 1; k <= 7; k++)
            tick(1, 16'h1000, fade_exp(k), 0, 3000 + k);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
